// File: rtl/qracc_csr_master_if.sv
// qracc_csr_master_if: single-beat CSR bus with read data returned one cycle after the handshake.
interface qracc_csr_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_data_o;
  logic              bus_wen_o;
  logic              bus_valid_o;
  logic              bus_ready_i;
  logic [DATA_W-1:0] rd_data_i;
  logic              rd_data_valid_i;
  modport master (
    output bus_addr_o, bus_data_o, bus_wen_o, bus_valid_o,
    input  bus_ready_i, rd_data_i, rd_data_valid_i
  );
  modport slave (
    input  bus_addr_o, bus_data_o, bus_wen_o, bus_valid_o,
    output bus_ready_i, rd_data_i, rd_data_valid_i
  );
endinterface

// File: rtl/qracc_csr_master.sv
// qracc_csr_master: turns write/read/poll commands into single-beat CSR bus transactions,
// one response per command.
module qracc_csr_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int POLL_MAX   = 1024,
  parameter int POLL_GAP   = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [DATA_W-1:0] cmd_mask_i,
  qracc_csr_master_if.master bus,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic              busy_o
);
  localparam int AW = $clog2(POLL_MAX + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 2);
  localparam logic [AW-1:0] PMAX  = AW'(POLL_MAX);
  localparam logic [TW-1:0] TLAST = TW'(RD_TIMEOUT - 1);
  localparam logic [GW-1:0] GLAST = GW'(POLL_GAP - 1);
  localparam logic [1:0] OP_WR = 2'd0, OP_RD = 2'd1, OP_RSV = 2'd3;
  typedef enum logic [2:0] {IDLE, REQ, RD_WAIT, GAP, RSP} state_t;
  state_t            state_q;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q, mask_q;
  logic [AW-1:0]     att_q;
  logic [TW-1:0]     tmr_q;
  logic [GW-1:0]     gap_q;
  logic              rd_match;
  assign rd_match = ((bus.rd_data_i ^ data_q) & mask_q) == '0;
  assign busy_o   = state_q != IDLE;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q         <= IDLE;
      op_q            <= '0;
      data_q          <= '0;
      mask_q          <= '0;
      att_q           <= '0;
      tmr_q           <= '0;
      gap_q           <= '0;
      cmd_ready_o     <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_data_o      <= '0;
      rsp_err_o       <= 1'b0;
      bus.bus_addr_o  <= '0;
      bus.bus_data_o  <= '0;
      bus.bus_wen_o   <= 1'b0;
      bus.bus_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid_i && cmd_ready_o) begin
          cmd_ready_o    <= 1'b0;
          op_q           <= cmd_op_i;
          data_q         <= cmd_data_i;
          mask_q         <= cmd_mask_i;
          att_q          <= PMAX;
          state_q        <= cmd_op_i == OP_RSV ? RSP : REQ;
          rsp_valid_o    <= cmd_op_i == OP_RSV;
          rsp_err_o      <= cmd_op_i == OP_RSV;
          rsp_data_o     <= '0;
          bus.bus_valid_o <= cmd_op_i != OP_RSV;
          bus.bus_addr_o <= cmd_addr_i;
          bus.bus_wen_o  <= cmd_op_i == OP_WR;
          bus.bus_data_o <= cmd_op_i == OP_WR ? cmd_data_i : '0;
        end else cmd_ready_o <= 1'b1;
        REQ: if (bus.bus_ready_i) begin
          bus.bus_valid_o <= 1'b0;
          state_q         <= op_q == OP_WR ? RSP : RD_WAIT;
          rsp_valid_o     <= op_q == OP_WR;
          rsp_data_o      <= '0;
          rsp_err_o       <= 1'b0;
          tmr_q           <= '0;
        end
        RD_WAIT: if (bus.rd_data_valid_i) begin
          if (op_q == OP_RD || rd_match || att_q == AW'(1)) begin
            state_q     <= RSP;
            rsp_valid_o <= 1'b1;
            rsp_data_o  <= bus.rd_data_i;
            rsp_err_o   <= op_q != OP_RD && !rd_match;
          end else begin
            // POLL_GAP of zero re-issues the read immediately
            att_q           <= att_q - 1'b1;
            gap_q           <= '0;
            state_q         <= POLL_GAP == 0 ? REQ : GAP;
            bus.bus_valid_o <= POLL_GAP == 0;
          end
        end else if (tmr_q == TLAST) begin
          state_q     <= RSP;
          rsp_valid_o <= 1'b1;
          rsp_data_o  <= '0;
          rsp_err_o   <= 1'b1;
        end else tmr_q <= tmr_q + 1'b1;
        GAP: if (gap_q == GLAST) begin
          state_q         <= REQ;
          bus.bus_valid_o <= 1'b1;
        end else gap_q <= gap_q + 1'b1;
        RSP: if (rsp_ready_i) begin
          rsp_valid_o <= 1'b0;
          cmd_ready_o <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
